frog_controller: RTL and testbench



---
 rtl/frog_controller.sv | 146 ++++++++++++++
 tb/tb_frog_controller.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/frog_controller.sv
// Frog position/score controller: debounced buttons queue one move that is committed on frame_tick,
// along with collision respawn and top-row scoring.

module frog_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic press
);
    localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

    logic          s1, s2, deb, deb_q;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            deb   <= 1'b0;
            deb_q <= 1'b0;
            cnt   <= '0;
        end else begin
            s1    <= raw;
            s2    <= s1;
            deb_q <= deb;
            // The flip happens on the DEBOUNCE_CYCLES-th consecutive differing cycle
            if (s2 == deb) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                deb <= s2;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign press = deb & ~deb_q;
endmodule

module frog_controller #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int GRID_COLS       = 20,
    parameter int GRID_ROWS       = 15,
    parameter int START_COL       = 10,
    parameter int START_ROW       = 14
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       frame_tick,
    input  logic       hit,
    output logic [4:0] frog_col,
    output logic [3:0] frog_row,
    output logic [7:0] score,
    output logic       win_pulse
);
    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    logic [3:0] raw, press;
    logic [1:0] press_dir, move_dir;
    logic       press_any, move_vld, hit_pending, land_top;
    logic [4:0] nxt_col;
    logic [3:0] nxt_row;

    assign raw = {btn_up, btn_down, btn_left, btn_right};

    for (genvar g = 0; g < 4; g++) begin : g_btn
        frog_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk   (clk),
            .rst   (rst),
            .raw   (raw[g]),
            .press (press[g])
        );
    end

    assign press_any = |press;

    always_comb begin
        press_dir = DIR_RIGHT;
        if (press[3])      press_dir = DIR_UP;
        else if (press[2]) press_dir = DIR_DOWN;
        else if (press[1]) press_dir = DIR_LEFT;
    end

    // Blocked moves at the edges leave the position untouched
    always_comb begin
        nxt_col = frog_col;
        nxt_row = frog_row;
        case (move_dir)
            DIR_UP:    if (frog_row != 4'd0) nxt_row = frog_row - 4'd1;
            DIR_DOWN:  if (frog_row != 4'(GRID_ROWS - 1)) nxt_row = frog_row + 4'd1;
            DIR_LEFT:  if (frog_col != 5'd0) nxt_col = frog_col - 5'd1;
            default:   if (frog_col != 5'(GRID_COLS - 1)) nxt_col = frog_col + 5'd1;
        endcase
        land_top = (nxt_row == 4'd0) && (frog_row != 4'd0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frog_col    <= 5'(START_COL);
            frog_row    <= 4'(START_ROW);
            score       <= 8'd0;
            win_pulse   <= 1'b0;
            move_vld    <= 1'b0;
            move_dir    <= DIR_UP;
            hit_pending <= 1'b0;
        end else begin
            win_pulse <= 1'b0;
            if (frame_tick) begin
                // A hit or press arriving with the tick is kept for the next tick
                hit_pending <= hit;
                move_vld    <= press_any;
                if (press_any) move_dir <= press_dir;
                if (hit_pending) begin
                    frog_col <= 5'(START_COL);
                    frog_row <= 4'(START_ROW);
                end else if (move_vld) begin
                    if (land_top) begin
                        frog_col  <= 5'(START_COL);
                        frog_row  <= 4'(START_ROW);
                        win_pulse <= 1'b1;
                        if (score != 8'hff) score <= score + 8'd1;
                    end else begin
                        frog_col <= nxt_col;
                        frog_row <= nxt_row;
                    end
                end
            end else begin
                hit_pending <= hit_pending | hit;
                if (!move_vld && press_any) begin
                    move_vld <= 1'b1;
                    move_dir <= press_dir;
                end
            end
        end
    end
endmodule

// File: tb/tb_frog_controller.sv
// Scoreboard bench for frog_controller: stimulus queues expected outputs per frame_tick/probe,
// a negedge monitor pops and compares.

module tb_frog_controller;
    localparam logic [3:0] B_UP = 4'b1000, B_DN = 4'b0100, B_LF = 4'b0010, B_RT = 4'b0001;

    logic       clk = 1'b0;
    logic       rst, frame_tick, hit, probe;
    logic [3:0] btn;
    logic [4:0] frog_col;
    logic [3:0] frog_row;
    logic [7:0] score;
    logic       win_pulse;

    typedef struct {
        logic [4:0] col;
        logic [3:0] row;
        logic [7:0] score;
        logic       win;
        int         id;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0, n_bad = 0, id_ctr = 0;
    logic ft_d = 1'b0;

    frog_controller #(.DEBOUNCE_CYCLES(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_up     (btn[3]),
        .btn_down   (btn[2]),
        .btn_left   (btn[1]),
        .btn_right  (btn[0]),
        .frame_tick (frame_tick),
        .hit        (hit),
        .frog_col   (frog_col),
        .frog_row   (frog_row),
        .score      (score),
        .win_pulse  (win_pulse)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ft_d <= frame_tick | probe;

    always @(negedge clk) begin
        if (ft_d) begin
            n_cmp++;
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL underflow: output sampled with no expectation queued");
            end else begin
                exp_t e;
                e = q.pop_front();
                if (frog_col !== e.col || frog_row !== e.row || score !== e.score || win_pulse !== e.win) begin
                    n_bad++;
                    $display("FAIL chk%0d: got col=%0d row=%0d score=%0d win=%0b, want col=%0d row=%0d score=%0d win=%0b",
                             e.id, frog_col, frog_row, score, win_pulse, e.col, e.row, e.score, e.win);
                end
            end
        end else if (win_pulse !== 1'b0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL stray_win: win_pulse=%0b outside a commit cycle, want 0", win_pulse);
        end
    end

    task automatic cyc(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(logic [4:0] c, logic [3:0] r, logic [7:0] s, logic w);
        exp_t e;
        e.col = c; e.row = r; e.score = s; e.win = w; e.id = id_ctr++;
        q.push_back(e);
    endtask

    task automatic tick(logic [4:0] c, logic [3:0] r, logic [7:0] s, logic w);
        frame_tick = 1'b1;
        push(c, r, s, w);
        cyc(1);
        frame_tick = 1'b0;
    endtask

    task automatic probe_now(logic [4:0] c, logic [3:0] r, logic [7:0] s, logic w);
        probe = 1'b1;
        push(c, r, s, w);
        cyc(1);
        probe = 1'b0;
    endtask

    // Press, let it debounce into the pending register, commit, then let the release settle
    task automatic move(logic [3:0] m, logic [4:0] c, logic [3:0] r, logic [7:0] s, logic w);
        btn = m;
        cyc(7);
        btn = 4'b0;
        tick(c, r, s, w);
        cyc(7);
    endtask

    initial begin
        int sc;
        rst = 1'b1; frame_tick = 1'b0; hit = 1'b0; probe = 1'b0; btn = 4'b0;
        cyc(3);
        rst = 1'b0;
        probe_now(10, 14, 0, 0);
        repeat (4) begin
            cyc(49);
            tick(10, 14, 0, 0);
        end

        // Held left: one move only
        btn = B_LF;
        cyc(10);
        tick(9, 14, 0, 0);
        cyc(20); tick(9, 14, 0, 0);
        cyc(20); tick(9, 14, 0, 0);
        btn = 4'b0;
        cyc(10);

        // Short glitch is filtered; simultaneous up+left keeps only up
        btn = B_RT; cyc(2); btn = 4'b0;
        cyc(20); tick(9, 14, 0, 0);
        btn = B_UP | B_LF; cyc(7); btn = 4'b0;
        tick(9, 13, 0, 0);
        cyc(7); tick(9, 13, 0, 0);

        // Hit respawn, then blocked down, then right
        hit = 1'b1; cyc(1); hit = 1'b0;
        cyc(5); tick(10, 14, 0, 0);
        move(B_DN, 10, 14, 0, 0);
        move(B_RT, 11, 14, 0, 0);

        // Press landing on the tick cycle is applied at the following tick
        btn = B_UP; cyc(6);
        tick(11, 14, 0, 0);
        btn = 4'b0; cyc(7);
        tick(11, 13, 0, 0);
        cyc(7);

        for (int r = 12; r >= 1; r--) move(B_UP, 11, 4'(r), 0, 0);
        move(B_UP, 10, 14, 1, 1);

        // Keep crossing until score saturates
        sc = 1;
        for (int k = 2; k <= 256; k++) begin
            for (int r = 13; r >= 1; r--) move(B_UP, 10, 4'(r), 8'(sc), 0);
            if (sc < 255) sc++;
            move(B_UP, 10, 14, 8'(sc), 1);
        end

        // Hit on the tick cycle is serviced one tick later
        move(B_UP, 10, 13, 255, 0);
        hit = 1'b1;
        tick(10, 13, 255, 0);
        hit = 1'b0;
        cyc(3); tick(10, 14, 255, 0);

        // Hit while left is pending discards the move
        move(B_UP, 10, 13, 255, 0);
        btn = B_LF; cyc(7); btn = 4'b0;
        hit = 1'b1; cyc(1); hit = 1'b0;
        cyc(8); tick(10, 14, 255, 0);
        cyc(5); tick(10, 14, 255, 0);

        // Reset mid-debounce
        btn = B_UP; cyc(4);
        rst = 1'b1; cyc(2);
        probe_now(10, 14, 0, 0);
        btn = 4'b0; cyc(2);
        rst = 1'b0; cyc(15);
        tick(10, 14, 0, 0);

        // Button held through reset release needs the full debounce
        btn = B_UP; rst = 1'b1; cyc(2);
        rst = 1'b0; cyc(5);
        tick(10, 14, 0, 0);
        cyc(3);
        tick(10, 13, 0, 0);
        btn = 4'b0; cyc(8);

        cyc(3);
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
